// File: rtl/latch_bank_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : latch_bank_scan_reader
// Description : Bank of DEPTH level-sensitive latch entries with a clocked
//               read-out sequencer. A start request snapshots the entries
//               one at a time into a register. Each snapshot is streamed over
//               a valid/ready interface together with its index.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : WIDTH  bits per latch entry
//               DEPTH  number of entries (>= 2)
// Ports       : clk        clock, rising edge
//               rst        synchronous active-high reset; also clears the
//                          latch bank while held high (level)
//               wr_en      write enable, makes the selected latch transparent
//               wr_addr    entry selected while wr_en is high
//               wr_data    data passed through to the selected entry
//               start      one-cycle request to scan the bank
//               out_valid  out_data/out_idx valid
//               out_ready  consumer accepts when valid & ready at an edge
//               out_data   registered snapshot of bank[out_idx]
//               out_idx    entry index of out_data
//               busy       scan in progress
//               done       one-cycle pulse after the last entry is accepted
//               out_parity XOR of out_data, present only when the macro
//                          LATCH_BANK_PARITY_EN is defined
// ============================================================================
module latch_bank_scan_reader #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_idx,
  output logic             busy,
  output logic             done
`ifdef LATCH_BANK_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Latch bank. The reset level overrides any write. An address at or above
  // DEPTH matches no entry, so nothing is written.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] bank [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_bank
    logic [WIDTH-1:0] entry;

    always_latch begin
      if (rst) begin
        entry <= '0;
      end else if (wr_en && (wr_addr == AW'(i))) begin
        entry <= wr_data;
      end
    end

    assign bank[i] = entry;
  end

  // --------------------------------------------------------------------------
  // Read-out sequencer
  // --------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state;
  logic             r_valid;
  logic             w_valid;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data;
  logic [AW-1:0]    r_idx;
  logic [AW-1:0]    w_idx;
  logic             r_done;
  logic             w_done;
  logic [AW-1:0]    w_next_idx;
  logic [AW-1:0]    w_load_idx;
  logic [WIDTH-1:0] w_load_entry;

  // One read port serves both load cases: entry 0 when a scan starts, and
  // the following entry when an accept advances the scan.
  assign w_next_idx   = r_idx + AW'(1);
  assign w_load_idx   = (r_state == IDLE) ? '0 : w_next_idx;
  assign w_load_entry = bank[w_load_idx];

  always_comb begin
    w_state = r_state;
    w_valid = r_valid;
    w_data  = r_data;
    w_idx   = r_idx;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_data  = w_load_entry;
          w_idx   = '0;
          w_valid = 1'b1;
          w_state = SEND;
        end
      end
      SEND: begin
        if (r_valid && out_ready) begin
          if (r_idx == AW'(DEPTH - 1)) begin
            w_valid = 1'b0;
            w_done  = 1'b1;
            w_state = IDLE;
          end else begin
            w_idx  = w_next_idx;
            w_data = w_load_entry;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_valid <= w_valid;
      r_data  <= w_data;
      r_idx   <= w_idx;
      r_done  <= w_done;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_idx   = r_idx;
  assign done      = r_done;
  assign busy      = (r_state == SEND);

`ifdef LATCH_BANK_PARITY_EN
  // Parity register follows out_data: it changes only on the same loads.
  logic r_parity;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_data != r_data || w_idx != r_idx || (w_valid && !r_valid)) begin
      r_parity <= ^w_data;
    end
  end

  assign out_parity = r_parity;
`endif

endmodule
`default_nettype wire

// File: tb/tb_latch_bank_scan_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_latch_bank_scan_reader
// Description : Scoreboard bench for latch_bank_scan_reader. A transaction
//               model pushes the expected beats. A monitor compares every
//               presented beat and the status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_latch_bank_scan_reader;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [AW-1:0]    out_idx;
  logic             busy;
  logic             done;
`ifdef LATCH_BANK_PARITY_EN
  logic             out_parity;
`endif

  latch_bank_scan_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done)
`ifdef LATCH_BANK_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: contents of the latch bank, and the scan as a transaction.
  logic [WIDTH-1:0] bank_m [DEPTH] = '{default: '0};

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [AW-1:0]    idx;
  } beat_t;

  beat_t exp_q[$];
  logic  m_scanning = 1'b0;
  logic  m_done     = 1'b0;
  int    m_cur      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change only here, right after a falling edge; the bank model
  // follows the latch rules at the same moment.
  task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                       input logic [WIDTH-1:0] wd, input logic st, input logic rdy);
    rst       = r;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    start     = st;
    out_ready = rdy;
    if (r) begin
      for (int k = 0; k < DEPTH; k++) bank_m[k] = '0;
    end else if (we && int'(wa) < DEPTH) begin
      bank_m[wa] = wd;
    end
  endtask

  function automatic void push_beat(input int k);
    beat_t b;
    b.data = bank_m[k];
    b.idx  = AW'(k);
    exp_q.push_back(b);
  endfunction

  // Transaction model: a scan snapshots entry 0 when it starts, and each
  // accepted entry causes the next one to be snapshot at the same edge.
  always @(posedge clk) begin
    if (rst) begin
      m_scanning <= 1'b0;
      m_cur      <= 0;
      m_done     <= 1'b0;
      exp_q.delete();
    end else begin
      m_done <= 1'b0;
      if (!m_scanning) begin
        if (start) begin
          push_beat(0);
          m_scanning <= 1'b1;
          m_cur      <= 0;
        end
      end else if (out_ready) begin
        if (m_cur == DEPTH - 1) begin
          m_scanning <= 1'b0;
          m_done     <= 1'b1;
        end else begin
          push_beat(m_cur + 1);
          m_cur <= m_cur + 1;
        end
      end
    end
  end

  // Monitor: samples shortly after each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      check("busy", 32'(busy), 32'(m_scanning));
      check("out_valid", 32'(out_valid), 32'(m_scanning));
      check("done", 32'(done), 32'(m_done));
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat: unexpected beat idx=%0d data=%0h, none expected at %0t",
                   out_idx, out_data, $time);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q[0].data));
          check("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
`ifdef LATCH_BANK_PARITY_EN
          check("out_parity", 32'(out_parity), 32'(^exp_q[0].data));
`endif
          if (out_ready && !rst) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_idx(input int k);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_idx == AW'(k)) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_idx: idx %0d never presented, out_idx=%0d", k, out_idx);
  endtask

  task automatic wait_done();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_done: done never pulsed, done=%0b", done);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    errors++;
    $display("FAIL watchdog: cycle budget exhausted, busy=%0b", busy);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst out_idx", 32'(out_idx), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

    // Full scan right after reset: every entry reads back zero.
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    wait_done();

    // Write 1,2,4,8 then stream them back-to-back.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk); drive(1'b0, 1'b1, AW'(i), WIDTH'(1 << i), 1'b0, 1'b0);
    end
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      if (k > 0) @(negedge clk);
      check("stream data", 32'(out_data), 32'(1 << k));
      check("stream idx", 32'(out_idx), 32'(k));
    end
    @(negedge clk);
    check("stream done", 32'(done), 32'd1);

    // Hold idx1 for three cycles while entry 1 is rewritten.
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    wait_idx(1);
    drive(1'b0, 1'b1, 2'd1, 4'hF, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("hold data", 32'(out_data), 32'h2);
      check("hold idx", 32'(out_idx), 32'd1);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    wait_done();

    // Write transparent at the start edge reaches the first snapshot.
    @(negedge clk); drive(1'b0, 1'b1, 2'd0, 4'hA, 1'b1, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    check("start-edge write", 32'(out_data), 32'hA);
    wait_done();

    // Reset mid-scan at idx2: scan aborted, no done.
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    wait_idx(2);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort out_data", 32'(out_data), 32'd0);
    repeat (5) begin
      @(negedge clk);
      check("abort no done", 32'(done), 32'd0);
    end

    // Start while busy is ignored; start alongside done begins a new scan.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk); drive(1'b0, 1'b1, AW'(i), WIDTH'($urandom), 1'b0, 1'b0);
    end
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    wait_idx(1);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    check("busy start ignored", 32'(out_idx), 32'd2);
    wait_done();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    check("restart valid", 32'(out_valid), 32'd1);
    check("restart idx", 32'(out_idx), 32'd0);
    wait_done();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 3),
            AW'($urandom), WIDTH'($urandom),
            ($urandom_range(0, 99) < 15), ($urandom_range(0, 9) < 6));
    end

    // Drain and confirm nothing is left outstanding.
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("drain queue", 32'(exp_q.size()), 32'd0);
    check("drain busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
